// File: rtl/skid_buffer.sv
// Two-entry register slice for a valid/ready stream with a saturating stall counter.
// Ports: clk/rst (async active-high); s_valid/s_ready/s_data upstream; m_valid/m_ready/m_data
// downstream; stall_cnt counts cycles with m_valid && !m_ready, stall_clr clears it.
// Latency 1 cycle when empty; s_ready, m_valid and m_data all come straight from flops.
module skid_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  input  logic                  stall_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_BUSY  = 2'd1,  // one word, in out_q
    ST_FULL  = 2'd2   // two words: out_q older, skid_q newer
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_hs;
  logic out_hs;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  assign in_hs  = s_valid && s_ready_q;
  assign out_hs = m_valid_q && m_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          out_d   = s_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_hs && out_hs) begin
          // Pass-through: the departing word is replaced in the same edge.
          out_d = s_data;
        end else if (in_hs) begin
          // Consumer stalled while s_ready was still high: park the word.
          skid_d  = s_data;
          state_d = ST_FULL;
        end else if (out_hs) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // s_ready is low here, so only the output side can move.
        if (out_hs) begin
          out_d   = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flags are derived from the next state and registered, which keeps
    // m_ready from ever reaching s_ready combinationally.
    s_ready_d = (state_d != ST_FULL);
    m_valid_d = (state_d != ST_EMPTY);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (m_valid_q && !m_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = out_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed vector table, async reset
// sequence, randomized stream against a queue model, and a 4-bit counter build.
module tb_skid_buffer;

  logic        clk;
  logic        rst;

  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [31:0] stall_cnt;
  logic        stall_clr;

  logic        s_valid4;
  logic        s_ready4;
  logic [7:0]  s_data4;
  logic        m_valid4;
  logic        m_ready4;
  logic [7:0]  m_data4;
  logic [3:0]  stall_cnt4;
  logic        stall_clr4;

  int n_cmp = 0;
  int n_err = 0;

  skid_buffer #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  skid_buffer #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
    .stall_cnt(stall_cnt4), .stall_clr(stall_clr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic        mr;
    logic        clr;
    logic        exp_mv;
    logic        exp_sr;
    logic [63:0] exp_md;
    logic [31:0] exp_cnt;
  } vec_t;

  function automatic vec_t vec(input logic sv, input logic [63:0] sd, input logic mr,
                               input logic clr, input logic mv, input logic sr,
                               input logic [63:0] md, input logic [31:0] cnt);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.clr = clr;
    v.exp_mv = mv; v.exp_sr = sr; v.exp_md = md; v.exp_cnt = cnt;
    return v;
  endfunction

  // One clock: inputs held across the edge, outputs sampled 1 time unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[$];
  logic [63:0] model_q[$];
  int          model_cnt;
  int          accepted;
  int          cycles;
  logic        m_in, m_out;
  logic        prev_hold;
  logic [63:0] prev_md;
  logic [63:0] pend;
  logic        have_pend;

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; stall_clr = 1'b0;
    s_valid4 = 1'b0; s_data4 = '0; m_ready4 = 1'b0; stall_clr4 = 1'b0;

    // ---- Reset values while reset is held ----
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_data", m_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst4_stall_cnt", stall_cnt4, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- Directed table: each record's expectations hold just after its edge ----
    for (int i = 1; i <= 8; i++)
      vecs.push_back(vec(1, 64'(i), 1, 0, 1, 1, 64'(i), 0));
    vecs.push_back(vec(0, 64'h0, 1, 0, 0, 1, 64'h8, 0));
    // Back-pressure from the start: A, B accepted, C waits.
    vecs.push_back(vec(1, 64'hA, 0, 0, 1, 1, 64'hA, 0));
    vecs.push_back(vec(1, 64'hB, 0, 0, 1, 0, 64'hA, 1));
    vecs.push_back(vec(1, 64'hC, 0, 0, 1, 0, 64'hA, 2));
    vecs.push_back(vec(1, 64'hC, 0, 0, 1, 0, 64'hA, 3));
    vecs.push_back(vec(1, 64'hC, 1, 0, 1, 1, 64'hB, 3));
    vecs.push_back(vec(1, 64'hC, 1, 0, 1, 1, 64'hC, 3));
    vecs.push_back(vec(0, 64'h0, 1, 0, 0, 1, 64'hC, 3));
    // Clear, then s_data without s_valid is ignored.
    vecs.push_back(vec(0, 64'h0, 1, 1, 0, 1, 64'hC, 0));
    vecs.push_back(vec(0, 64'hDEAD, 1, 0, 0, 1, 64'hC, 0));
    // BUSY with neither handshake holds.
    vecs.push_back(vec(1, 64'h11, 1, 0, 1, 1, 64'h11, 0));
    vecs.push_back(vec(0, 64'h0, 0, 0, 1, 1, 64'h11, 1));
    vecs.push_back(vec(0, 64'h0, 1, 0, 0, 1, 64'h11, 1));
    vecs.push_back(vec(0, 64'h0, 1, 1, 0, 1, 64'h11, 0));

    foreach (vecs[i]) begin
      s_valid = vecs[i].sv; s_data = vecs[i].sd;
      m_ready = vecs[i].mr; stall_clr = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].exp_mv);
      chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].exp_sr);
      chk($sformatf("vec%0d_m_data", i), m_data, vecs[i].exp_md);
      chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, vecs[i].exp_cnt);
    end
    stall_clr = 1'b0;

    // ---- Async reset while FULL with 0x55, 0x66 ----
    s_valid = 1; s_data = 64'h55; m_ready = 0; tick();
    s_valid = 1; s_data = 64'h66; m_ready = 0; tick();
    chk("full_s_ready", s_ready, 0);
    chk("full_m_data", m_data, 64'h55);
    s_valid = 0; s_data = '0; m_ready = 1;
    #2 rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_s_ready", s_ready, 1);
    chk("arst_m_data", m_data, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_m_valid", m_valid, 0);
    end
    s_valid = 1; s_data = 64'h77; tick();
    chk("post_rst_first_word", m_data, 64'h77);
    chk("post_rst_first_valid", m_valid, 1);
    s_valid = 0; tick();
    chk("post_rst_drain_valid", m_valid, 0);
    chk("post_rst_stall_cnt", stall_cnt, 0);

    // ---- Randomized stream against a queue-occupancy model ----
    model_q.delete();
    model_cnt = 0;
    accepted = 0;
    cycles = 0;
    have_pend = 0;
    pend = '0;
    while (accepted < 10000 && cycles < 40000) begin
      if (!have_pend) begin
        pend = {$urandom, $urandom};
        have_pend = ($urandom_range(0, 9) < 7);
      end
      s_valid = have_pend;
      s_data  = have_pend ? pend : {$urandom, $urandom};
      m_ready = ($urandom_range(0, 9) < 6);
      prev_hold = m_valid && !m_ready;
      prev_md   = m_data;
      m_in  = s_valid && (model_q.size() < 2);
      m_out = (model_q.size() > 0) && m_ready;
      if (model_q.size() > 0 && !m_ready) model_cnt++;
      tick();
      cycles++;
      if (m_out) void'(model_q.pop_front());
      if (m_in) begin
        model_q.push_back(pend);
        accepted++;
        have_pend = 0;
      end
      chk("rand_m_valid", m_valid, (model_q.size() > 0));
      chk("rand_s_ready", s_ready, (model_q.size() < 2));
      if (model_q.size() > 0) chk("rand_m_data", m_data, model_q[0]);
      if (prev_hold) chk("rand_m_data_stable", m_data, prev_md);
      chk("rand_stall_cnt", stall_cnt, 64'(model_cnt));
    end
    chk("rand_words_accepted", 64'(accepted), 64'd10000);
    s_valid = 0; m_ready = 1;
    for (int i = 0; i < 3; i++) begin
      m_out = (model_q.size() > 0);
      tick();
      if (m_out) void'(model_q.pop_front());
      chk("drain_m_valid", m_valid, (model_q.size() > 0));
      if (model_q.size() > 0) chk("drain_m_data", m_data, model_q[0]);
    end

    // ---- 4-bit counter build: saturation and clear priority ----
    s_valid4 = 1; s_data4 = 8'h5A; m_ready4 = 0; tick();
    s_valid4 = 0; s_data4 = '0;
    chk("sat_first_cnt", stall_cnt4, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat_cnt_k%0d", k), stall_cnt4, (k > 15) ? 15 : k);
    end
    chk("sat_m_data_held", m_data4, 8'h5A);
    chk("sat_m_valid", m_valid4, 1);
    stall_clr4 = 1; tick();
    chk("clr_cnt_zero", stall_cnt4, 0);
    stall_clr4 = 0; tick();
    chk("clr_cnt_one", stall_cnt4, 1);
    chk("clr_m_data_held", m_data4, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
